// File: rtl/ddr_wr_burst_ctrl.sv
// Drains the pixel write FIFO into fixed-length AXI4 INCR write bursts that walk
// a linear frame buffer, wrapping at the frame end and flagging write errors.
module ddr_wr_burst_ctrl #(
    parameter int                    BURST_LEN   = 16,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 28,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    FRAME_BYTES = 3686400
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    frame_sync,
    output logic                    fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    input  logic                    fifo_rd_empty,
    input  logic [14:0]             fifo_rd_water_level,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    wr_err
);

    localparam int                    CNT_W       = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0]      LEN_CNT     = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]      LAST_BEAT   = CNT_W'(BURST_LEN - 1);
    localparam logic [14:0]           LEVEL_MIN   = 15'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] FRAME_SIZE  = ADDR_WIDTH'(FRAME_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   off_reg;
    logic [ADDR_WIDTH-1:0]   off_inc;
    logic                    sync_pend_reg;
    logic [CNT_W-1:0]        rd_cnt_reg;
    logic [CNT_W-1:0]        beat_cnt_reg;
    logic                    inflight_reg;
    logic [1:0]              occ_reg;
    logic                    wr_ptr_reg;
    logic                    rd_ptr_reg;
    logic [2:0]              credit;
    logic                    start;
    logic                    prefetch;
    logic                    beat_fire;
    logic                    wrap;
    logic [DATA_WIDTH-1:0]   entry_data [2];

    assign m_awlen   = 8'(BURST_LEN - 1);
    assign m_awsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_awburst = 2'b01;
    assign m_wstrb   = '1;

    assign start     = (state_reg == S_IDLE) && enable && (fifo_rd_water_level >= LEVEL_MIN);
    assign prefetch  = (state_reg == S_AW) || (state_reg == S_W);
    assign beat_fire = m_wvalid && m_wready;
    assign off_inc   = off_reg + BURST_BYTES;
    assign wrap      = (off_inc == FRAME_SIZE);

    // A beat leaving the buffer this cycle frees a slot, which keeps one beat per cycle streaming.
    assign credit     = 3'(occ_reg) + 3'(inflight_reg) - 3'(beat_fire);
    assign fifo_rd_en = prefetch && (rd_cnt_reg < LEN_CNT) && !fifo_rd_empty && (credit < 3'd2);

    // Two-entry output buffer; each entry captures the FIFO word the cycle after its read.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_buf
            logic [DATA_WIDTH-1:0] entry_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (inflight_reg && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= fifo_rd_data;
                end
            end
            assign entry_data[gi] = entry_reg;
        end
    endgenerate

    assign m_wdata = entry_data[rd_ptr_reg];

    always_comb begin
        state_next = state_reg;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_wlast    = 1'b0;
        m_bready   = 1'b0;
        busy       = (state_reg != S_IDLE);
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_AW;
                end
            end
            S_AW: begin
                m_awvalid = 1'b1;
                if (m_awready) begin
                    state_next = S_W;
                end
            end
            S_W: begin
                m_wvalid = (occ_reg != 2'd0);
                m_wlast  = (beat_cnt_reg == LAST_BEAT);
                if (m_wvalid && m_wready && m_wlast) begin
                    state_next = S_B;
                end
            end
            S_B: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            off_reg       <= '0;
            sync_pend_reg <= 1'b0;
            m_awaddr      <= BASE_ADDR;
            rd_cnt_reg    <= '0;
            beat_cnt_reg  <= '0;
            inflight_reg  <= 1'b0;
            occ_reg       <= '0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            frame_done    <= 1'b0;
            wr_err        <= 1'b0;
        end else begin
            state_reg    <= state_next;
            frame_done   <= 1'b0;
            inflight_reg <= fifo_rd_en;
            occ_reg      <= occ_reg + 2'(inflight_reg) - 2'(beat_fire);
            if (fifo_rd_en) begin
                rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
            end
            if (inflight_reg) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (beat_fire) begin
                rd_ptr_reg   <= ~rd_ptr_reg;
                beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
            end
            case (state_reg)
                S_IDLE: begin
                    rd_cnt_reg   <= '0;
                    beat_cnt_reg <= '0;
                    if (frame_sync) begin
                        off_reg <= '0;
                    end
                    if (start) begin
                        m_awaddr <= BASE_ADDR + (frame_sync ? '0 : off_reg);
                    end
                end
                S_B: begin
                    if (m_bvalid) begin
                        if (m_bresp != 2'b00) begin
                            wr_err <= 1'b1;
                        end
                        frame_done    <= wrap;
                        // A pending resync overrides the normal advance.
                        off_reg       <= (wrap || sync_pend_reg || frame_sync) ? '0 : off_inc;
                        sync_pend_reg <= 1'b0;
                    end else if (frame_sync) begin
                        sync_pend_reg <= 1'b1;
                    end
                end
                default: begin
                    if (frame_sync) begin
                        sync_pend_reg <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// Bench for ddr_wr_burst_ctrl: FIFO and AXI slave models, a per-burst vector table
// and hand sequences for level threshold, latency, resync and reset.
module tb_ddr_wr_burst_ctrl;

    localparam logic [27:0] BASE = 28'h0001000;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        frame_sync;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data;
    logic        fifo_rd_empty;
    logic [14:0] fifo_rd_water_level;
    logic [27:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wlast;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic        busy;
    logic        frame_done;
    logic        wr_err;

    ddr_wr_burst_ctrl #(
        .BURST_LEN  (16),
        .DATA_WIDTH (32),
        .ADDR_WIDTH (28),
        .BASE_ADDR  (BASE),
        .FRAME_BYTES(128)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .frame_sync         (frame_sync),
        .fifo_rd_en         (fifo_rd_en),
        .fifo_rd_data       (fifo_rd_data),
        .fifo_rd_empty      (fifo_rd_empty),
        .fifo_rd_water_level(fifo_rd_water_level),
        .m_awaddr           (m_awaddr),
        .m_awlen            (m_awlen),
        .m_awsize           (m_awsize),
        .m_awburst          (m_awburst),
        .m_awvalid          (m_awvalid),
        .m_awready          (m_awready),
        .m_wdata            (m_wdata),
        .m_wstrb            (m_wstrb),
        .m_wlast            (m_wlast),
        .m_wvalid           (m_wvalid),
        .m_wready           (m_wready),
        .m_bresp            (m_bresp),
        .m_bvalid           (m_bvalid),
        .m_bready           (m_bready),
        .busy               (busy),
        .frame_done         (frame_done),
        .wr_err             (wr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          wr_pct;
        logic [1:0]  bresp;
        bit          sync_in_w;
        bit          hold_off;
        logic [27:0] exp_addr;
        int          exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    // Reference state: FIFO contents, expected write order, and observed AXI traffic.
    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic        last_q[$];
    logic [27:0] aw_q[$];
    int          beat_cyc[$];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   wr_pct = 100;
    logic [1:0] bresp_val = 2'b00;
    bit   b_pend = 0;
    bit   rd_pend = 0;
    logic [31:0] rd_pend_val;
    int   b_cnt = 0;
    int   fd_cnt = 0;
    int   rd_en_cnt = 0;
    int   rd_empty_viol = 0;
    int   aw_attr_bad = 0;
    int   strb_bad = 0;
    int   first_aw_cyc = -1;
    int   first_rd_cyc = -1;
    int   first_wv_cyc = -1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // FIFO read side and AXI slave: drive at negedge, then observe what the next posedge will accept.
    initial begin
        fifo_rd_data        = '0;
        fifo_rd_empty       = 1'b1;
        fifo_rd_water_level = '0;
        m_awready           = 1'b0;
        m_wready            = 1'b0;
        m_bvalid            = 1'b0;
        m_bresp             = 2'b00;
        forever begin
            @(negedge clk);
            cyc++;
            if (rd_pend) begin
                fifo_rd_data = rd_pend_val;
                rd_pend      = 0;
            end
            fifo_rd_empty       = (fifo_q.size() == 0);
            fifo_rd_water_level = 15'(fifo_q.size());
            m_awready = ($urandom_range(99) < wr_pct);
            m_wready  = ($urandom_range(99) < wr_pct);
            m_bvalid  = b_pend;
            m_bresp   = b_pend ? bresp_val : 2'b00;
            #1;
            if (!rst) begin
                if (m_awvalid && first_aw_cyc < 0) first_aw_cyc = cyc;
                if (m_wvalid && first_wv_cyc < 0) first_wv_cyc = cyc;
                if (fifo_rd_en) begin
                    rd_en_cnt++;
                    if (first_rd_cyc < 0) first_rd_cyc = cyc;
                    if (fifo_q.size() == 0) begin
                        rd_empty_viol++;
                    end else begin
                        rd_pend_val = fifo_q.pop_front();
                        rd_pend     = 1;
                    end
                end
                if (m_awvalid && m_awready) begin
                    aw_q.push_back(m_awaddr);
                    if (m_awlen != 8'd15 || m_awsize != 3'd2 || m_awburst != 2'b01) aw_attr_bad++;
                end
                if (m_wvalid && m_wready) begin
                    got_q.push_back(m_wdata);
                    last_q.push_back(m_wlast);
                    beat_cyc.push_back(cyc);
                    if (m_wstrb != 4'hF) strb_bad++;
                    if (m_wlast) b_pend = 1;
                end
                if (m_bvalid && m_bready) begin
                    b_pend = 0;
                    b_cnt++;
                end
                if (frame_done) fd_cnt++;
            end
        end
    end

    task automatic push_word(input logic [31:0] w);
        @(posedge clk);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic finish_burst(input int k, input logic [27:0] exp_addr, input int exp_done,
                                input logic exp_err, input int b0, input int fd0, input int rd0);
        int          t;
        int          data_bad;
        int          last_bad;
        logic [27:0] a;
        logic [31:0] g;
        logic        l;
        t = 0;
        while (b_cnt == b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("b%0d_bresp_wait", k), (t < 3000), 1);
        repeat (3) @(negedge clk);
        #2;
        check($sformatf("b%0d_aw_count", k), aw_q.size(), 1);
        a = (aw_q.size() > 0) ? aw_q.pop_front() : '1;
        check($sformatf("b%0d_awaddr", k), a, exp_addr);
        check($sformatf("b%0d_beat_count", k), got_q.size(), 16);
        data_bad = 0;
        last_bad = 0;
        for (int i = 0; i < 16; i++) begin
            g = (got_q.size() > 0) ? got_q.pop_front() : 32'hDEAD_BEEF;
            l = (last_q.size() > 0) ? last_q.pop_front() : 1'bx;
            if (exp_q.size() == 0 || g !== exp_q.pop_front()) data_bad++;
            if (l !== (i == 15)) last_bad++;
        end
        check($sformatf("b%0d_wdata_order_bad", k), data_bad, 0);
        check($sformatf("b%0d_wlast_bad", k), last_bad, 0);
        check($sformatf("b%0d_rd_en_count", k), rd_en_cnt - rd0, 16);
        check($sformatf("b%0d_frame_done", k), fd_cnt - fd0, exp_done);
        check($sformatf("b%0d_wr_err", k), wr_err, exp_err);
        $display("burst %0d: awaddr=%h beats_bad=%0d frame_done=%0d wr_err=%0b",
                 k, a, data_bad, fd_cnt - fd0, wr_err);
        got_q.delete();
        last_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int b0;
        int fd0;
        int rd0;
        int hold_bad;
        int t;
        int span;

        vecs[0] = '{50,  2'b00, 1'b0, 1'b1, BASE + 28'd64, 1, 1'b0};
        vecs[1] = '{50,  2'b00, 1'b0, 1'b0, BASE,          0, 1'b0};
        vecs[2] = '{50,  2'b00, 1'b0, 1'b0, BASE + 28'd64, 1, 1'b0};
        vecs[3] = '{50,  2'b10, 1'b0, 1'b0, BASE,          0, 1'b1};
        vecs[4] = '{100, 2'b00, 1'b1, 1'b0, BASE + 28'd64, 1, 1'b1};
        vecs[5] = '{50,  2'b00, 1'b1, 1'b0, BASE,          0, 1'b1};
        vecs[6] = '{100, 2'b00, 1'b0, 1'b0, BASE,          0, 1'b1};
        vecs[7] = '{50,  2'b00, 1'b0, 1'b0, BASE + 28'd64, 1, 1'b1};

        rst        = 1'b1;
        enable     = 1'b0;
        frame_sync = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_fifo_rd_en", fifo_rd_en, 0);
        check("rst_awvalid", m_awvalid, 0);
        check("rst_wvalid", m_wvalid, 0);
        check("rst_wlast", m_wlast, 0);
        check("rst_bready", m_bready, 0);
        check("rst_awaddr", m_awaddr, BASE);
        check("rst_wdata", m_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_wr_err", wr_err, 0);
        rst    = 1'b0;
        enable = 1'b1;

        // Burst 0: level 15 must not start; data 0..15 with every channel ready.
        wr_pct = 100;
        b0 = b_cnt; fd0 = fd_cnt; rd0 = rd_en_cnt;
        first_aw_cyc = -1; first_rd_cyc = -1; first_wv_cyc = -1;
        beat_cyc.delete();
        for (int i = 0; i < 15; i++) push_word(32'(i));
        hold_bad = 0;
        repeat (6) begin
            @(negedge clk);
            #2;
            if (m_awvalid || busy) hold_bad++;
        end
        check("level15_no_aw", hold_bad, 0);
        push_word(32'd15);
        @(negedge clk);
        #2;
        check("aw_same_cycle_as_level16", m_awvalid, 0);
        @(negedge clk);
        #2;
        check("aw_cycle_after_level16", m_awvalid, 1);
        finish_burst(0, BASE, 0, 1'b0, b0, fd0, rd0);
        check("first_rd_in_first_aw_cycle", first_rd_cyc, first_aw_cyc);
        check("first_wvalid_ge_2_after_rd", ((first_wv_cyc - first_rd_cyc) >= 2), 1);
        span = (beat_cyc.size() == 16) ? (beat_cyc[15] - beat_cyc[0]) : -1;
        check("no_bubbles_span", span, 15);

        for (int k = 0; k < 8; k++) begin
            wr_pct    = vecs[k].wr_pct;
            bresp_val = vecs[k].bresp;
            b0 = b_cnt; fd0 = fd_cnt; rd0 = rd_en_cnt;
            beat_cyc.delete();
            if (vecs[k].hold_off) enable = 1'b0;
            for (int i = 0; i < 16; i++) push_word($urandom);
            if (vecs[k].hold_off) begin
                hold_bad = 0;
                repeat (8) begin
                    @(negedge clk);
                    #2;
                    if (m_awvalid || busy) hold_bad++;
                end
                check("enable_low_blocks", hold_bad, 0);
                enable = 1'b1;
            end
            if (vecs[k].sync_in_w) begin
                t = 0;
                while (!m_wvalid && t < 500) begin
                    @(negedge clk);
                    #2;
                    t++;
                end
                check("sync_wait_wvalid", (t < 500), 1);
                frame_sync = 1'b1;
                @(negedge clk);
                frame_sync = 1'b0;
            end
            finish_burst(k + 1, vecs[k].exp_addr, vecs[k].exp_done, vecs[k].exp_err, b0, fd0, rd0);
        end

        check("never_read_empty", rd_empty_viol, 0);
        check("aw_attributes_bad", aw_attr_bad, 0);
        check("wstrb_bad", strb_bad, 0);

        // Reset in the middle of a burst clears everything at once, including the sticky error.
        wr_pct = 30;
        for (int i = 0; i < 16; i++) push_word($urandom);
        t = 0;
        while (!m_wvalid && t < 500) begin
            @(negedge clk);
            #2;
            t++;
        end
        check("midburst_reached_w", busy, 1);
        rst = 1'b1;
        #2;
        check("midrst_busy", busy, 0);
        check("midrst_awvalid", m_awvalid, 0);
        check("midrst_wvalid", m_wvalid, 0);
        check("midrst_fifo_rd_en", fifo_rd_en, 0);
        check("midrst_awaddr", m_awaddr, BASE);
        check("midrst_wr_err", wr_err, 0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
